// File: rtl/alu_op_issue_pkg.sv
// Shared ALU control encodings: slice selects, ALUOp/funct codes, decoded control bundle.
package alu_op_issue_pkg;

    // Slice select codes understood by every ALU bit slice
    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;

    // ALUOp field from the main control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // R-type funct codes handled by the ALU
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Decoded per-op controls, stored alongside the operands
    typedef struct packed {
        logic [2:0] sel;
        logic       binv;
        logic       cin;
        logic       illegal;
    } ctrl_t;

    // Occupancy of the output/skid storage pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    localparam ctrl_t CTRL_RESET = '{sel: SEL_ADD, binv: 1'b0, cin: 1'b0, illegal: 1'b0};

    // Subtract and set-less-than both need B inverted plus a carry-in of one
    function automatic ctrl_t make_ctrl(input logic [2:0] sel, input logic illegal);
        ctrl_t c;
        c.sel     = sel;
        c.binv    = (sel == SEL_SUB) || (sel == SEL_SLT);
        c.cin     = (sel == SEL_SUB) || (sel == SEL_SLT);
        c.illegal = illegal;
        return c;
    endfunction

endpackage

// File: rtl/alu_op_issue_decode.sv
// Combinational ALUOp/funct decoder producing slice controls; unknown encodings fall back to ADD.
module alu_op_decode
    import alu_op_issue_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    logic [2:0] sel;
    logic       illegal;

    // Map the ALUOp/funct pair onto a slice select, flagging anything unrecognised
    always_comb begin
        sel     = SEL_ADD;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: sel = SEL_ADD;
            ALUOP_SUB: sel = SEL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: sel = SEL_ADD;
                    FUNCT_SUB: sel = SEL_SUB;
                    FUNCT_AND: sel = SEL_AND;
                    FUNCT_OR:  sel = SEL_OR;
                    FUNCT_SLT: sel = SEL_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            ALUOP_RSVD: illegal = 1'b1;
            default:    illegal = 1'b1;
        endcase
        ctrl = make_ctrl(sel, illegal);
    end

endmodule

// File: rtl/alu_op_issue.sv
// EX-stage issue front end: decodes ops once on entry and holds them in an output register
// plus a single skid register so downstream stalls never drop or duplicate an operation.
module alu_op_issue
    import alu_op_issue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_sel,
    output logic             out_binv,
    output logic             out_cin,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    state_t           state;
    state_t           next_state;
    ctrl_t            in_ctrl;
    ctrl_t            out_ctrl;
    ctrl_t            skid_ctrl;
    logic [WIDTH-1:0] skid_a;
    logic [WIDTH-1:0] skid_b;
    logic             accept;
    logic             fire;
    logic             load_out_in;
    logic             load_out_skid;
    logic             load_skid;

    alu_op_decode u_decode (
        .aluop (in_aluop),
        .funct (in_funct),
        .ctrl  (in_ctrl)
    );

    assign out_valid   = (state != ST_EMPTY);
    assign accept      = in_valid && in_ready;
    assign fire        = out_valid && out_ready;
    assign out_sel     = out_ctrl.sel;
    assign out_binv    = out_ctrl.binv;
    assign out_cin     = out_ctrl.cin;
    assign out_illegal = out_ctrl.illegal;

    // State register; in_ready is registered and drops only while the skid entry is occupied
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != ST_FULL);
        end
    end

    // Next-state logic from the input/output handshakes
    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_ONE;
            ST_ONE: begin
                if (fire && !accept)      next_state = ST_EMPTY;
                else if (!fire && accept) next_state = ST_FULL;
            end
            ST_FULL:  if (fire) next_state = ST_ONE;
            default:  next_state = ST_EMPTY;
        endcase
    end

    // Datapath load enables; FULL never accepts because in_ready is low there
    always_comb begin
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: load_out_in = accept;
            ST_ONE: begin
                load_out_in = accept && fire;
                load_skid   = accept && !fire;
            end
            ST_FULL:  load_out_skid = fire;
            default: ;
        endcase
    end

    // Output and skid registers holding operands together with their decoded controls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_a     <= '0;
            out_b     <= '0;
            out_ctrl  <= CTRL_RESET;
            skid_a    <= '0;
            skid_b    <= '0;
            skid_ctrl <= CTRL_RESET;
        end else begin
            if (load_out_in) begin
                out_a    <= in_a;
                out_b    <= in_b;
                out_ctrl <= in_ctrl;
            end else if (load_out_skid) begin
                out_a    <= skid_a;
                out_b    <= skid_b;
                out_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_a    <= in_a;
                skid_b    <= in_b;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // Saturating count of illegal encodings accepted at the input
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && in_ctrl.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule
